// File: rtl/tbird_lamp_scheduler.sv
// Tail-lamp sequencer for the turn-signal design: synchronizes the three
// active-low buttons and steps a Moore FSM on a prescaled tick.
module tbird_lamp_scheduler #(
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       hazard_button,
  output logic [2:0] left_leds,
  output logic [2:0] right_leds,
  output logic       hazard_active,
  output logic       tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_L1      = 4'd1,
    ST_L2      = 4'd2,
    ST_L3      = 4'd3,
    ST_R1      = 4'd4,
    ST_R2      = 4'd5,
    ST_R3      = 4'd6,
    ST_HAZ_ON  = 4'd7,
    ST_HAZ_OFF = 4'd8
  } state_t;

  // Buttons packed as {hazard, right, left}; still active-low here.
  logic [2:0]       btn_meta_r;
  logic [2:0]       btn_sync_r;
  logic [CNT_W-1:0] count_r;
  logic             tick_r;
  state_t           state_r;
  state_t           state_next_s;
  logic             req_l_s;
  logic             req_r_s;
  logic             req_hz_s;
  logic [2:0]       left_pat_s;
  logic [2:0]       right_pat_s;
  logic             haz_pat_s;
  logic [2:0]       left_leds_r;
  logic [2:0]       right_leds_r;
  logic             hazard_active_r;

  // Two-flop synchronizer; reset value is "released".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_r <= 3'b111;
      btn_sync_r <= 3'b111;
    end else begin
      btn_meta_r <= {hazard_button, right_button, left_button};
      btn_sync_r <= btn_meta_r;
    end
  end

  assign req_l_s  = ~btn_sync_r[0];
  assign req_r_s  = ~btn_sync_r[1];
  assign req_hz_s = ~btn_sync_r[2] | (req_l_s & req_r_s);

  // Free-running prescaler; tick_r is registered so it is high exactly while count_r == TICK_DIV-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      if (count_r == CNT_LAST) begin
        count_r <= {CNT_W{1'b0}};
      end else begin
        count_r <= count_r + CNT_ONE;
      end
      tick_r <= (count_r == CNT_PRE);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: hazard first, then turn start from IDLE, then fixed stepping.
  always_comb begin
    state_next_s = state_r;
    if (tick_r) begin
      if (req_hz_s) begin
        if (state_r == ST_HAZ_ON) begin
          state_next_s = ST_HAZ_OFF;
        end else begin
          state_next_s = ST_HAZ_ON;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (req_l_s) begin
              state_next_s = ST_L1;
            end else if (req_r_s) begin
              state_next_s = ST_R1;
            end else begin
              state_next_s = ST_IDLE;
            end
          end
          ST_L1:      state_next_s = ST_L2;
          ST_L2:      state_next_s = ST_L3;
          ST_R1:      state_next_s = ST_R2;
          ST_R2:      state_next_s = ST_R3;
          default:    state_next_s = ST_IDLE;
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Lamp pattern for the state being entered, so outputs change on the same edge as the state.
  always_comb begin
    left_pat_s  = 3'b000;
    right_pat_s = 3'b000;
    haz_pat_s   = 1'b0;
    case (state_next_s)
      ST_L1:      left_pat_s  = 3'b001;
      ST_L2:      left_pat_s  = 3'b011;
      ST_L3:      left_pat_s  = 3'b111;
      ST_R1:      right_pat_s = 3'b001;
      ST_R2:      right_pat_s = 3'b011;
      ST_R3:      right_pat_s = 3'b111;
      ST_HAZ_ON: begin
        left_pat_s  = 3'b111;
        right_pat_s = 3'b111;
        haz_pat_s   = 1'b1;
      end
      ST_HAZ_OFF: haz_pat_s   = 1'b1;
      default: begin
        left_pat_s  = 3'b000;
        right_pat_s = 3'b000;
        haz_pat_s   = 1'b0;
      end
    endcase
  end

  // Registered lamp outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      left_leds_r     <= 3'b000;
      right_leds_r    <= 3'b000;
      hazard_active_r <= 1'b0;
    end else begin
      left_leds_r     <= left_pat_s;
      right_leds_r    <= right_pat_s;
      hazard_active_r <= haz_pat_s;
    end
  end

  assign left_leds     = left_leds_r;
  assign right_leds    = right_leds_r;
  assign hazard_active = hazard_active_r;
  assign tick          = tick_r;

endmodule

// File: tb/tb_tbird_lamp_scheduler.sv
// Scoreboard bench for tbird_lamp_scheduler with TICK_DIV=4: a mode/step
// reference model queues expected outputs, a monitor compares them.
module tb_tbird_lamp_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       left_button = 1'b1;
  logic       right_button = 1'b1;
  logic       hazard_button = 1'b1;
  logic [2:0] left_leds;
  logic [2:0] right_leds;
  logic       hazard_active;
  logic       tick;

  int vectors = 0;
  int miscompares = 0;

  // expected item: {tick, hazard_active, left_leds, right_leds}
  logic [7:0] exp_q[$];

  tbird_lamp_scheduler #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .left_button(left_button),
    .right_button(right_button),
    .hazard_button(hazard_button),
    .left_leds(left_leds),
    .right_leds(right_leds),
    .hazard_active(hazard_active),
    .tick(tick)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0=idle 1=left 2=right 3=hazard; step = lamp count or hazard phase.
  int         k = 0;
  int         mode = 0;
  int         step = 0;
  logic [2:0] hist[$] = '{3'b111, 3'b111};

  initial begin
    logic [2:0] used;
    logic       rl, rr, rhz;
    logic [2:0] el, er;
    logic       eh;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        k = 0; mode = 0; step = 0;
        hist = '{3'b111, 3'b111};
        exp_q.delete();
      end else begin
        used = hist.pop_front();
        hist.push_back({hazard_button, right_button, left_button});
        rl  = ~used[0];
        rr  = ~used[1];
        rhz = ~used[2] | (rl & rr);
        if (k % 4 == 3) begin
          if (rhz) begin
            if (mode == 3 && step == 0) step = 1;
            else begin mode = 3; step = 0; end
          end else if (mode == 3) begin
            mode = 0; step = 0;
          end else if (mode == 0) begin
            if (rl) begin mode = 1; step = 1; end
            else if (rr) begin mode = 2; step = 1; end
          end else begin
            step = step + 1;
            if (step == 4) begin mode = 0; step = 0; end
          end
        end
        k = k + 1;
        el = 3'b000; er = 3'b000; eh = 1'b0;
        if (mode == 1) el = 3'((1 << step) - 1);
        if (mode == 2) er = 3'((1 << step) - 1);
        if (mode == 3) begin
          eh = 1'b1;
          if (step == 0) begin el = 3'b111; er = 3'b111; end
        end
        exp_q.push_back({(k % 4 == 3), eh, el, er});
      end
    end
  end

  // Monitor: every clock the DUT presents a new output set; compare at the falling edge.
  initial begin
    logic [7:0] e;
    logic [7:0] a;
    forever begin
      @(negedge clock);
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {tick, hazard_active, left_leds, right_leds};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got tick/haz/L/R=%b/%b/%b/%b expected %b/%b/%b/%b",
                   $time, a[7], a[6], a[5:3], a[2:0], e[7], e[6], e[5:3], e[2:0]);
        end
      end
    end
  end

  task automatic drive(input logic l, input logic r, input logic h, input int n);
    left_button = l; right_button = r; hazard_button = h;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({tick, hazard_active, left_leds, right_leds} !== 8'h00) begin
      miscompares++;
      $display("FAIL %s got tick/haz/L/R=%b/%b/%b/%b expected all zero",
               name, tick, hazard_active, left_leds, right_leds);
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clock);
    check_zero("reset_state");
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 14);
    drive(1'b0, 1'b1, 1'b1, 22);                   // hold left: repeated passes
    drive(1'b1, 1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 1'b1, 6);                    // short right press
    drive(1'b1, 1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 1'b1, 7);                    // left pass, then hazard over it
    drive(1'b0, 1'b1, 1'b0, 18);
    drive(1'b1, 1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 1'b1, 13);                   // both -> hazard
    drive(1'b0, 1'b1, 1'b1, 14);                   // release right only
    drive(1'b1, 1'b1, 1'b1, 10);
    // hold right until R3, then reset asynchronously mid-cycle
    right_button = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (right_leds == 3'b111) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL wait_r3 got no R3 within 40 clocks expected R3");
    end
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clock); @(negedge clock);
    check_zero("reset_hold");
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 12);
    // randomized phase: each button toggles with low probability per clock
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) left_button   = ~left_button;
      if ($urandom_range(0, 15) == 0) right_button  = ~right_button;
      if ($urandom_range(0, 31) == 0) hazard_button = ~hazard_button;
      if ($urandom_range(0, 499) == 0) begin
        #3 reset_n = 1'b0;
        #1 check_zero("rand_reset");
        @(negedge clock);
        reset_n = 1'b1;
      end
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected at most 1", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tbird_lamp_scheduler.md
Name: tbird_lamp_scheduler

Overview:
- Central sequencer for the six tail-lamp LEDs on the DE1-SoC turn-signal design.
- Arbitrates the LEFT, RIGHT and HAZARD pushbutton requests and owns the single shared lamp bank.
- Advances a Moore state machine on a divided-down tick and drives registered LED patterns.
- Replaces per-signal ad-hoc sequencing with one prescaler, one state register and a fixed priority.

Parameters:
- TICK_DIV, 12500000: clocks per tick (0.25 s at 50 MHz). Legal range is 2..2^24-1.
- CNT_W, 24: prescaler counter width. Must hold TICK_DIV-1.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- left_button  in  1  left request, active-low, asynchronous to clock
- right_button  in  1  right request, active-low, asynchronous to clock
- hazard_button  in  1  hazard request, active-low, asynchronous to clock
- left_leds  out  3  left lamps; bit0 = innermost (LA), bit2 = outermost (LC)
- right_leds  out  3  right lamps; bit0 = innermost (RA), bit2 = outermost (RC)
- hazard_active  out  1  high while in HAZ_ON or HAZ_OFF
- tick  out  1  one-clock prescaler pulse, for bench and debug

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, prescaler=0, tick=0, all LEDs=0, hazard_active=0, sync flops=1 (released).
- Input sync: each button passes through a 2-flop synchronizer. The decoded requests are active-high: L, R, H.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 on exactly the clock where count==TICK_DIV-1. Free-running, independent of state.
- State changes only on clocks where tick=1. Outputs are registered and update on the same edge as the state.
- Effective hazard request HZ = H | (L & R).
- States and output patterns (left_leds/right_leds):
  - IDLE 000/000
  - L1 001/000, L2 011/000, L3 111/000
  - R1 000/001, R2 000/011, R3 000/111
  - HAZ_ON 111/111, HAZ_OFF 000/000
- Transitions on tick; priority top to bottom:
  - Any state, HZ=1: go to HAZ_ON. From HAZ_ON go to HAZ_OFF; from HAZ_OFF go to HAZ_ON. Hazard preempts an in-progress turn immediately.
  - IDLE: L -> L1; R -> R1; otherwise stay in IDLE.
  - L1->L2->L3->IDLE and R1->R2->R3->IDLE unconditionally (when HZ=0). Releasing or switching direction mid-pass does not abort the pass.
  - HAZ_ON or HAZ_OFF with HZ=0: go to IDLE.
- A held request repeats passes. The cycle is L1,L2,L3,IDLE,L1,..., so one dark tick always separates passes.
- A request pulse shorter than one tick is missed unless it is present at a tick edge. This is by design; no latching.
- Request-to-lamp latency: 2 clocks of sync, then up to TICK_DIV clocks to the next tick, then 1 clock to the registered output.
- Reset asserted mid-pass or mid-hazard forces IDLE with LEDs off at once. After release the prescaler restarts from 0.
- No illegal states are reachable. Any unencoded state value decodes to IDLE on the next tick; LEDs are off while in it.

Test Plan (TICK_DIV=4, so a tick every 4 clocks):
- Reset with all buttons high: LEDs 000/000, hazard_active=0. tick pulses at clocks 3, 7, 11 after reset release.
- Hold left_button=0: left_leds steps 001, 011, 111, 000, 001 on successive ticks. right_leds stays 000 throughout.
- Press right_button for 6 clocks covering exactly one tick, then release: one full pass 001, 011, 111, 000, then IDLE is held.
- During the left pass at L2, assert hazard_button=0: next tick gives 111/111 with hazard_active=1. Subsequent ticks alternate 000/000 and 111/111. On release, the next tick gives IDLE 000/000.
- Assert left_button=0 and right_button=0 together from IDLE: behaves as hazard (HAZ_ON on the first tick). Release right only: the hazard ends, then the next tick enters L1.
- Assert reset_n=0 while in R3: right_leds=000 immediately, with no clock edge required. After release with right held, R1 appears at the 4th clock.
